// File: rtl/axi4_lite_master_arbiter_if.sv
// AXI4-Lite bus between the two-requester arbiter (master) and a single slave.
// Every channel uses valid/ready: a beat transfers on a rising edge where both are high; the source holds its payload until then.
interface axi4_lite_master_arbiter_if #(
    parameter int G_AXI4_LITE_ADDR_WIDTH = 32,
    parameter int G_AXI4_LITE_DATA_WIDTH = 32
);
    logic                                  awvalid;
    logic                                  awready;
    logic [G_AXI4_LITE_ADDR_WIDTH-1:0]     awaddr;
    logic [2:0]                            awprot;
    logic                                  wvalid;
    logic                                  wready;
    logic [G_AXI4_LITE_DATA_WIDTH-1:0]     wdata;
    logic [G_AXI4_LITE_DATA_WIDTH/8-1:0]   wstrb;
    logic                                  bready;
    logic                                  bvalid;
    logic [1:0]                            bresp;
    logic                                  arvalid;
    logic                                  arready;
    logic [G_AXI4_LITE_ADDR_WIDTH-1:0]     araddr;
    logic [2:0]                            arprot;
    logic                                  rready;
    logic                                  rvalid;
    logic [G_AXI4_LITE_DATA_WIDTH-1:0]     rdata;
    logic [1:0]                            rresp;

    modport master (
        output awvalid, awaddr, awprot, input awready,
        output wvalid, wdata, wstrb, input wready,
        output bready, input bvalid, bresp,
        output arvalid, araddr, arprot, input arready,
        output rready, input rvalid, rdata, rresp
    );

    modport slave (
        input awvalid, awaddr, awprot, output awready,
        input wvalid, wdata, wstrb, output wready,
        input bready, output bvalid, bresp,
        input arvalid, araddr, arprot, output arready,
        input rready, output rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi4_lite_master_arbiter.sv
// Round-robin arbiter that serialises single-beat accesses from two requesters
// onto one AXI4-Lite master port; all outputs come straight from registers.
module axi4_lite_master_arbiter #(
    parameter int G_AXI4_LITE_ADDR_WIDTH = 32,
    parameter int G_AXI4_LITE_DATA_WIDTH = 32
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [1:0]                             req,
    input  logic [1:0]                             we,
    input  logic [2*G_AXI4_LITE_ADDR_WIDTH-1:0]    addr,
    input  logic [2*G_AXI4_LITE_DATA_WIDTH-1:0]    wdata,
    input  logic [G_AXI4_LITE_DATA_WIDTH/4-1:0]    wstrb,
    output logic [1:0]                             ack,
    output logic [G_AXI4_LITE_DATA_WIDTH-1:0]      rdata,
    output logic [1:0]                             resp,
    output logic                                   busy,
    output logic [2:0]                             state_dbg,
    axi4_lite_master_arbiter_if.master             m_axi
);
    localparam int AW = G_AXI4_LITE_ADDR_WIDTH;
    localparam int DW = G_AXI4_LITE_DATA_WIDTH;
    localparam int SW = DW / 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t          state;
    logic            last_grant;
    logic            grant;
    logic            gnt_next;
    logic            sel_we;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;
    logic [SW-1:0]   sel_wstrb;

    assign state_dbg    = state;
    assign m_axi.awprot = 3'b000;
    assign m_axi.arprot = 3'b000;

    // On a tie the requester that was not served last wins.
    always_comb begin
        gnt_next  = (req == 2'b11) ? ~last_grant : req[1];
        sel_we    = gnt_next ? we[1] : we[0];
        sel_addr  = gnt_next ? addr[2*AW-1:AW]  : addr[AW-1:0];
        sel_wdata = gnt_next ? wdata[2*DW-1:DW] : wdata[DW-1:0];
        sel_wstrb = gnt_next ? wstrb[2*SW-1:SW] : wstrb[SW-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            grant         <= 1'b0;
            ack           <= 2'b00;
            rdata         <= '0;
            resp          <= 2'b00;
            busy          <= 1'b0;
            m_axi.awvalid <= 1'b0;
            m_axi.awaddr  <= '0;
            m_axi.wvalid  <= 1'b0;
            m_axi.wdata   <= '0;
            m_axi.wstrb   <= '0;
            m_axi.bready  <= 1'b0;
            m_axi.arvalid <= 1'b0;
            m_axi.araddr  <= '0;
            m_axi.rready  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant      <= gnt_next;
                        last_grant <= gnt_next;
                        busy       <= 1'b1;
                        if (sel_we) begin
                            state         <= WR;
                            m_axi.awvalid <= 1'b1;
                            m_axi.wvalid  <= 1'b1;
                            m_axi.awaddr  <= sel_addr;
                            m_axi.wdata   <= sel_wdata;
                            m_axi.wstrb   <= sel_wstrb;
                        end else begin
                            state         <= RD_ADDR;
                            m_axi.arvalid <= 1'b1;
                            m_axi.araddr  <= sel_addr;
                        end
                    end
                end
                WR: begin
                    // Address and data handshakes retire independently, in any order.
                    if (m_axi.awready) m_axi.awvalid <= 1'b0;
                    if (m_axi.wready)  m_axi.wvalid  <= 1'b0;
                    if ((!m_axi.awvalid || m_axi.awready) &&
                        (!m_axi.wvalid  || m_axi.wready)) begin
                        state        <= WR_RESP;
                        m_axi.bready <= 1'b1;
                    end
                end
                WR_RESP: begin
                    if (m_axi.bvalid) begin
                        resp         <= m_axi.bresp;
                        m_axi.bready <= 1'b0;
                        ack          <= grant ? 2'b10 : 2'b01;
                        state        <= DONE;
                    end
                end
                RD_ADDR: begin
                    if (m_axi.arready) begin
                        m_axi.arvalid <= 1'b0;
                        m_axi.rready  <= 1'b1;
                        state         <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (m_axi.rvalid) begin
                        rdata        <= m_axi.rdata;
                        resp         <= m_axi.rresp;
                        m_axi.rready <= 1'b0;
                        ack          <= grant ? 2'b10 : 2'b01;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    ack   <= 2'b00;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_axi4_lite_master_arbiter.sv
// Directed bench for the two-requester AXI4-Lite arbiter; the bench plays the slave.
module tb_axi4_lite_master_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [2:0] ST_IDLE = 3'd0, ST_WR = 3'd1, ST_WR_RESP = 3'd2,
                           ST_RD_ADDR = 3'd3, ST_RD_DATA = 3'd4, ST_DONE = 3'd5;

    logic            clk;
    logic            rst;
    logic [1:0]      req;
    logic [1:0]      we;
    logic [2*AW-1:0] addr;
    logic [2*DW-1:0] wdata;
    logic [DW/4-1:0] wstrb;
    logic [1:0]      ack;
    logic [DW-1:0]   rdata;
    logic [1:0]      resp;
    logic            busy;
    logic [2:0]      state_dbg;

    int tests_run;
    int tests_failed;

    axi4_lite_master_arbiter_if #(
        .G_AXI4_LITE_ADDR_WIDTH(AW),
        .G_AXI4_LITE_DATA_WIDTH(DW)
    ) axi ();

    axi4_lite_master_arbiter #(
        .G_AXI4_LITE_ADDR_WIDTH(AW),
        .G_AXI4_LITE_DATA_WIDTH(DW)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .wstrb(wstrb), .ack(ack), .rdata(rdata), .resp(resp), .busy(busy),
        .state_dbg(state_dbg), .m_axi(axi.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic slave_idle();
        axi.awready = 1'b0; axi.wready = 1'b0; axi.arready = 1'b0;
        axi.bvalid = 1'b0; axi.bresp = 2'b00;
        axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = 2'b00;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 2'b00; we = 2'b00; addr = '0; wdata = '0; wstrb = '0;
        slave_idle();
        tick(); tick();
        tests_run++;
        if (state_dbg !== ST_IDLE || busy !== 1'b0 || ack !== 2'b00) begin
            $display("FAIL reset_ctrl state=%0d busy=%b ack=%b exp 0/0/00", state_dbg, busy, ack); tests_failed++;
        end
        tests_run++;
        if ({axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready} !== 5'b0) begin
            $display("FAIL reset_axi_hs act=%b exp=00000", {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}); tests_failed++;
        end
        tests_run++;
        if (axi.awaddr !== '0 || axi.araddr !== '0 || axi.wdata !== '0 || axi.wstrb !== '0 || rdata !== '0 || resp !== 2'b00) begin
            $display("FAIL reset_data awaddr=%h araddr=%h wdata=%h wstrb=%h rdata=%h resp=%b exp all 0",
                     axi.awaddr, axi.araddr, axi.wdata, axi.wstrb, rdata, resp); tests_failed++;
        end
        tests_run++;
        if (axi.awprot !== 3'b000 || axi.arprot !== 3'b000) begin
            $display("FAIL prot aw=%b ar=%b exp 000", axi.awprot, axi.arprot); tests_failed++;
        end
        rst = 1'b0;
    endtask

    task automatic test_read();
        axi.arready = 1'b1;
        req = 2'b10; we = 2'b00; addr[2*AW-1:AW] = 32'h24; addr[AW-1:0] = 32'h0;
        tick();
        tests_run++;
        if (state_dbg !== ST_RD_ADDR || axi.arvalid !== 1'b1 || axi.araddr !== 32'h24 || busy !== 1'b1) begin
            $display("FAIL rd_addr state=%0d arvalid=%b araddr=%h busy=%b exp 3/1/24/1", state_dbg, axi.arvalid, axi.araddr, busy); tests_failed++;
        end
        tick();
        axi.arready = 1'b0;
        tests_run++;
        if (state_dbg !== ST_RD_DATA || axi.rready !== 1'b1 || axi.arvalid !== 1'b0) begin
            $display("FAIL rd_data_phase state=%0d rready=%b arvalid=%b exp 4/1/0", state_dbg, axi.rready, axi.arvalid); tests_failed++;
        end
        repeat (4) tick();
        tests_run++;
        if (state_dbg !== ST_RD_DATA || ack !== 2'b00) begin
            $display("FAIL rd_wait state=%0d ack=%b exp 4/00", state_dbg, ack); tests_failed++;
        end
        axi.rvalid = 1'b1; axi.rdata = 32'h12345678; axi.rresp = 2'b10;
        tick();
        axi.rvalid = 1'b0; axi.rdata = '0; req = 2'b00;
        tests_run++;
        if (state_dbg !== ST_DONE || ack !== 2'b10 || rdata !== 32'h12345678 || resp !== 2'b10 || axi.rready !== 1'b0) begin
            $display("FAIL rd_done state=%0d ack=%b rdata=%h resp=%b rready=%b exp 5/10/12345678/10/0",
                     state_dbg, ack, rdata, resp, axi.rready); tests_failed++;
        end
        tick();
        tests_run++;
        if (state_dbg !== ST_IDLE || ack !== 2'b00 || busy !== 1'b0) begin
            $display("FAIL rd_idle state=%0d ack=%b busy=%b exp 0/00/0", state_dbg, ack, busy); tests_failed++;
        end
    endtask

    task automatic test_single_write();
        axi.awready = 1'b1; axi.wready = 1'b1;
        req = 2'b01; we = 2'b01; addr[AW-1:0] = 32'h10; wdata[DW-1:0] = 32'hA5A5A5A5; wstrb[3:0] = 4'hF;
        tick();
        tests_run++;
        if (state_dbg !== ST_WR || axi.awvalid !== 1'b1 || axi.wvalid !== 1'b1 || axi.awaddr !== 32'h10 ||
            axi.wdata !== 32'hA5A5A5A5 || axi.wstrb !== 4'hF) begin
            $display("FAIL wr_issue state=%0d awv=%b wv=%b awaddr=%h wdata=%h wstrb=%h exp 1/1/1/10/a5a5a5a5/f",
                     state_dbg, axi.awvalid, axi.wvalid, axi.awaddr, axi.wdata, axi.wstrb); tests_failed++;
        end
        tick();
        axi.awready = 1'b0; axi.wready = 1'b0;
        tests_run++;
        if (state_dbg !== ST_WR_RESP || axi.bready !== 1'b1 || axi.awvalid !== 1'b0 || axi.wvalid !== 1'b0) begin
            $display("FAIL wr_resp_phase state=%0d bready=%b awv=%b wv=%b exp 2/1/0/0", state_dbg, axi.bready, axi.awvalid, axi.wvalid); tests_failed++;
        end
        axi.bvalid = 1'b1; axi.bresp = 2'b00;
        tick();
        axi.bvalid = 1'b0; req = 2'b00;
        tests_run++;
        if (state_dbg !== ST_DONE || ack !== 2'b01 || resp !== 2'b00 || axi.bready !== 1'b0) begin
            $display("FAIL wr_done state=%0d ack=%b resp=%b bready=%b exp 5/01/00/0", state_dbg, ack, resp, axi.bready); tests_failed++;
        end
        tick();
        tests_run++;
        if (state_dbg !== ST_IDLE || ack !== 2'b00 || busy !== 1'b0) begin
            $display("FAIL wr_idle state=%0d ack=%b busy=%b exp 0/00/0", state_dbg, ack, busy); tests_failed++;
        end
    endtask

    task automatic test_split_write();
        int acks;
        acks = 0;
        axi.awready = 1'b0; axi.wready = 1'b1;
        req = 2'b01; we = 2'b01; addr[AW-1:0] = 32'h40; wdata[DW-1:0] = 32'hDEADBEEF; wstrb[3:0] = 4'h3;
        tick();
        tick();
        axi.wready = 1'b0;
        tests_run++;
        if (state_dbg !== ST_WR || axi.wvalid !== 1'b0 || axi.awvalid !== 1'b1 || axi.bready !== 1'b0) begin
            $display("FAIL split_w_first state=%0d wv=%b awv=%b bready=%b exp 1/0/1/0", state_dbg, axi.wvalid, axi.awvalid, axi.bready); tests_failed++;
        end
        tick(); tick();
        tests_run++;
        if (state_dbg !== ST_WR || axi.awvalid !== 1'b1 || axi.awaddr !== 32'h40 || axi.bready !== 1'b0) begin
            $display("FAIL split_aw_hold state=%0d awv=%b awaddr=%h bready=%b exp 1/1/40/0", state_dbg, axi.awvalid, axi.awaddr, axi.bready); tests_failed++;
        end
        axi.awready = 1'b1;
        tick();
        axi.awready = 1'b0;
        tests_run++;
        if (state_dbg !== ST_WR_RESP || axi.awvalid !== 1'b0 || axi.bready !== 1'b1) begin
            $display("FAIL split_resp state=%0d awv=%b bready=%b exp 2/0/1", state_dbg, axi.awvalid, axi.bready); tests_failed++;
        end
        axi.bvalid = 1'b1; axi.bresp = 2'b01;
        for (int c = 0; c < 3; c++) begin
            tick();
            axi.bvalid = 1'b0;
            if (ack != 2'b00) acks++;
            if (ack == 2'b01) req = 2'b00;
        end
        tests_run++;
        if (acks !== 1 || resp !== 2'b01 || busy !== 1'b0) begin
            $display("FAIL split_ack acks=%0d resp=%b busy=%b exp 1/01/0", acks, resp, busy); tests_failed++;
        end
    endtask

    task automatic test_contention();
        logic [1:0] exp_ack [4];
        int n;
        exp_ack = '{2'b01, 2'b10, 2'b01, 2'b10};
        n = 0;
        rst = 1'b1; req = 2'b11; we = 2'b10;
        axi.awready = 1'b1; axi.wready = 1'b1; axi.arready = 1'b1;
        axi.bvalid = 1'b1; axi.bresp = 2'b00; axi.rvalid = 1'b1; axi.rdata = 32'h0BADF00D; axi.rresp = 2'b00;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 60 && n < 4; c++) begin
            tick();
            if (ack != 2'b00) begin
                tests_run++;
                if (ack !== exp_ack[n]) begin
                    $display("FAIL contention_order idx=%0d act=%b exp=%b", n, ack, exp_ack[n]); tests_failed++;
                end
                n++;
                tick();
                tests_run++;
                if (state_dbg !== ST_IDLE || busy !== 1'b0) begin
                    $display("FAIL contention_gap state=%0d busy=%b exp 0/0", state_dbg, busy); tests_failed++;
                end
                tick();
                tests_run++;
                if (busy !== 1'b1) begin
                    $display("FAIL contention_regrant busy=%b exp 1", busy); tests_failed++;
                end
            end
        end
        tests_run++;
        if (n !== 4) begin
            $display("FAIL contention_timeout acks=%0d exp 4", n); tests_failed++;
        end
        req = 2'b00;
        slave_idle();
    endtask

    task automatic test_reset_mid_read();
        rst = 1'b1; tick(); rst = 1'b0;
        axi.arready = 1'b1;
        req = 2'b01; we = 2'b00; addr[AW-1:0] = 32'h30; addr[2*AW-1:AW] = 32'h99;
        tick(); tick();
        tests_run++;
        if (state_dbg !== ST_RD_DATA || axi.rready !== 1'b1) begin
            $display("FAIL mid_rd_setup state=%0d rready=%b exp 4/1", state_dbg, axi.rready); tests_failed++;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++;
        if (state_dbg !== ST_IDLE || busy !== 1'b0 || ack !== 2'b00 ||
            {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready} !== 5'b0) begin
            $display("FAIL mid_rd_reset state=%0d busy=%b ack=%b hs=%b exp 0/0/00/00000", state_dbg, busy, ack,
                     {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}); tests_failed++;
        end
        tick();
        tests_run++;
        if (state_dbg !== ST_RD_ADDR || axi.araddr !== 32'h30) begin
            $display("FAIL mid_rd_regrant state=%0d araddr=%h exp 3/30", state_dbg, axi.araddr); tests_failed++;
        end
        axi.rvalid = 1'b1; axi.rdata = 32'hCAFE0001; axi.rresp = 2'b00;
        tick(); tick();
        axi.rvalid = 1'b0; req = 2'b00; axi.arready = 1'b0;
        tests_run++;
        if (ack !== 2'b01 || rdata !== 32'hCAFE0001) begin
            $display("FAIL mid_rd_complete ack=%b rdata=%h exp 01/cafe0001", ack, rdata); tests_failed++;
        end
        tick();
    endtask

    task automatic test_stray();
        req = 2'b00;
        axi.bvalid = 1'b1; axi.bresp = 2'b11; axi.rvalid = 1'b1; axi.rdata = 32'hFFFFFFFF; axi.rresp = 2'b11;
        for (int c = 0; c < 3; c++) begin
            tick();
            tests_run++;
            if (state_dbg !== ST_IDLE || ack !== 2'b00 || busy !== 1'b0 || rdata !== 32'hCAFE0001 || resp !== 2'b00) begin
                $display("FAIL stray cyc=%0d state=%0d ack=%b busy=%b rdata=%h resp=%b exp 0/00/0/cafe0001/00",
                         c, state_dbg, ack, busy, rdata, resp); tests_failed++;
            end
        end
        slave_idle();
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_read();
        test_single_write();
        test_split_write();
        test_contention();
        test_reset_mid_read();
        test_stray();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/axi4_lite_master_arbiter.md
AXI4_LITE_MASTER_ARBITER -- requirements
Module: axi4_lite_master_arbiter

Interface
REQ-001 SHALL have parameter G_AXI4_LITE_ADDR_WIDTH, default 32, AXI address width in bits.
REQ-002 SHALL have parameter G_AXI4_LITE_DATA_WIDTH, default 32, AXI data width in bits; legal values are 32 and 64 only.
REQ-003 clk  in  1  single clock; all logic rising-edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 req  in  2  bit i is the access request from requester i; held high until ack[i].
REQ-006 we  in  2  bit i: 1 = write, 0 = read; stable while req[i] is high.
REQ-007 addr  in  2*AW  slice i is the requester i byte address.
REQ-008 wdata  in  2*DW  slice i is the requester i write data.
REQ-009 wstrb  in  2*DW/8  slice i is the requester i write strobes.
REQ-010 ack  out  2  one-cycle completion pulse to requester i.
REQ-011 rdata  out  DW  read data of the last completed read.
REQ-012 resp  out  2  AXI response of the last completed access.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 The AXI4-Lite master port SHALL be: awvalid, awaddr, awprot, awready, wvalid, wdata, wstrb, wready, bready, bvalid, bresp, arvalid, araddr, arprot, arready, rready, rvalid, rdata, rresp, with standard directions and widths.

Function
REQ-015 FSM states SHALL be IDLE, WR, WR_RESP, RD_ADDR, RD_DATA and DONE; every output SHALL be registered.
REQ-016 IDLE grant rules:
- req = 01 or 10: grant that requester.
- req = 11: grant the requester not in last_grant (round-robin).
- req = 00: stay in IDLE.
REQ-017 On a grant, the arbiter SHALL latch the requester's we, addr, wdata and wstrb, and set last_grant to the granted index; requester inputs are not sampled again until the next IDLE.
REQ-018 Write path:
- Grant in cycle N: awvalid and wvalid high in cycle N+1, state WR.
- Each valid drops on its own handshake (awready or wready sampled high); the two handshakes may complete in the same cycle or in either order.
- Once both have completed: go to WR_RESP with bready high.
REQ-019 Read path:
- Grant in cycle N: arvalid high in cycle N+1, state RD_ADDR.
- On arready: go to RD_DATA with rready high.
REQ-020 On bvalid&bready: capture bresp into resp, clear bready, go to DONE. On rvalid&rready: capture rdata and rresp, clear rready, go to DONE.
REQ-021 DONE SHALL last exactly one cycle with ack[grant] high, then return to IDLE; the earliest next grant is the cycle after DONE.
REQ-022 awprot and arprot SHALL always be 3'b000.
REQ-023 awaddr/wdata/wstrb SHALL be constant while their valids are high; araddr SHALL be constant while arvalid is high.
REQ-024 bvalid outside WR_RESP and rvalid outside RD_DATA SHALL be ignored (bready and rready are low there).
REQ-025 No requester SHALL be granted twice in a row while the other has req high.
REQ-026 A req deassert by a requester before its ack is a protocol violation; the latched transaction SHALL still complete and ack SHALL still pulse.
REQ-027 There is no timeout: the FSM SHALL wait indefinitely for ready, bvalid or rvalid.

Reset
REQ-028 While rst is high at a rising edge, the next-cycle values SHALL be:
- state IDLE;
- all AXI valids and readies low; awaddr, araddr, wdata, wstrb 0;
- ack 00, rdata 0, resp 00, busy 0;
- last_grant 1, so requester 0 wins the first tie.
REQ-029 Reset mid-transaction SHALL abandon the transaction without issuing ack.

Verification
REQ-030 Single write: req=01, we=01, addr0=0x10, wdata0=0xA5A5A5A5, wstrb0=0xF, slave ready immediately, bresp=00 -> awvalid/wvalid one cycle after grant, awaddr=0x10, ack=01 once, resp=00, busy low after DONE.
REQ-031 Split write handshake: wready 3 cycles before awready -> wvalid drops after its handshake, awvalid held until awready, single bready phase, exactly one ack.
REQ-032 Read: req=10, addr1=0x24, slave returns rdata=0x12345678 with rresp=10 after 4 wait cycles -> araddr=0x24, rdata=0x12345678, resp=10, ack=10.
REQ-033 Contention: req=11 held continuously from reset -> grant order 0,1,0,1; acks alternate; one IDLE cycle between transactions.
REQ-034 Reset mid-read: rst asserted in RD_DATA before rvalid -> next cycle all valids/readies low, ack=00, busy=0; after rst falls, pending req=01 is granted requester 0.
REQ-035 Stray bvalid/rvalid pulses while IDLE -> no state change, no ack.
